// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcode map, flag bit
// positions, controller state encoding and opcode classification helpers.
package alu_ctrl_pkg;

    localparam logic [5:0] OP_ADD = 6'h09;
    localparam logic [5:0] OP_SUB = 6'h0A;
    localparam logic [5:0] OP_LSR = 6'h0B;
    localparam logic [5:0] OP_LSL = 6'h0C;
    localparam logic [5:0] OP_RSR = 6'h0D;
    localparam logic [5:0] OP_RSL = 6'h0E;
    localparam logic [5:0] OP_MOV = 6'h0F;
    localparam logic [5:0] OP_MUL = 6'h10;
    localparam logic [5:0] OP_DIV = 6'h11;
    localparam logic [5:0] OP_MOD = 6'h12;
    localparam logic [5:0] OP_AND = 6'h13;
    localparam logic [5:0] OP_OR  = 6'h14;
    localparam logic [5:0] OP_XOR = 6'h15;
    localparam logic [5:0] OP_NOT = 6'h16;
    localparam logic [5:0] OP_CMP = 6'h17;
    localparam logic [5:0] OP_TST = 6'h18;
    localparam logic [5:0] OP_INC = 6'h19;
    localparam logic [5:0] OP_DEC = 6'h1A;

    localparam logic [5:0] OP_MIN = OP_ADD;
    localparam logic [5:0] OP_MAX = OP_DEC;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [5:0] op);
        return (op >= OP_MIN) && (op <= OP_MAX);
    endfunction

    function automatic logic is_muldiv(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_divmod(input logic [5:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first asserted request found
// searching upward (with wrap) from the priority pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic found_s;
    int   idx_s;

    // Rotating priority search starting at ptr_i.
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_s && req_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the shared combinational ALU: arbitrates requesters,
// holds operands for the per-opcode EXEC time, returns tagged responses.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int MULDIV_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [6*NUM_REQ-1:0]    req_opcode,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_id,
    output logic [16:0]             rsp_result,
    output logic [3:0]              rsp_flags,
    output logic                    rsp_err,
    output logic [15:0]             alu_a,
    output logic [15:0]             alu_b,
    output logic [5:0]              alu_opcode,
    output logic                    alu_op,
    input  logic [16:0]             alu_result,
    input  logic                    alu_zf,
    input  logic                    alu_cf,
    input  logic                    alu_nf,
    input  logic                    alu_of,
    output logic [3:0]              status_flags,
    output logic                    busy
);

    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    state_t          state_q;
    logic [1:0]      rr_ptr_q;
    logic [1:0]      rr_ptr_d;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      rsp_id_q;
    logic [16:0]     rsp_result_q;
    logic [3:0]      rsp_flags_q;
    logic            rsp_err_q;
    logic            rsp_valid_q;
    logic [15:0]     alu_a_q;
    logic [15:0]     alu_b_q;
    logic [5:0]      alu_opcode_q;
    logic            alu_op_q;
    logic [3:0]      status_q;

    logic [NUM_REQ-1:0] gnt_s;
    logic [1:0]         win_s;
    logic [5:0]         win_op_s;
    logic [15:0]        win_a_s;
    logic [15:0]        win_b_s;
    logic               win_err_s;
    logic [3:0]         alu_flags_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt_s)
    );

    // AND-OR select of the granted requester's index, opcode and operands.
    always_comb begin
        win_s    = 2'd0;
        win_op_s = 6'h00;
        win_a_s  = 16'h0000;
        win_b_s  = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_s    = win_s    | (gnt_s[i] ? 2'(i)                   : 2'd0);
            win_op_s = win_op_s | (gnt_s[i] ? req_opcode[6*i +: 6]    : 6'h00);
            win_a_s  = win_a_s  | (gnt_s[i] ? req_a[16*i +: 16]       : 16'h0000);
            win_b_s  = win_b_s  | (gnt_s[i] ? req_b[16*i +: 16]       : 16'h0000);
        end
        win_err_s = !is_legal(win_op_s) || (is_divmod(win_op_s) && (win_b_s == 16'h0000));
        rr_ptr_d  = (win_s == 2'(NUM_REQ - 1)) ? 2'd0 : win_s + 2'd1;
    end

    // Pack ALU flags into the architectural {ZF,CF,NF,OF} layout.
    always_comb begin
        alu_flags_s         = 4'b0000;
        alu_flags_s[FLAG_Z] = alu_zf;
        alu_flags_s[FLAG_C] = alu_cf;
        alu_flags_s[FLAG_N] = alu_nf;
        alu_flags_s[FLAG_O] = alu_of;
    end

    // Grant is combinational and only offered while idle and out of reset.
    always_comb begin
        if ((state_q == IDLE) && !rst) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    // Controller FSM with all datapath and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 2'd0;
            cnt_q        <= '0;
            rsp_id_q     <= 2'd0;
            rsp_result_q <= 17'h00000;
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= 16'h0000;
            alu_b_q      <= 16'h0000;
            alu_opcode_q <= 6'h00;
            alu_op_q     <= 1'b0;
            status_q     <= 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|gnt_s) begin
                        rr_ptr_q <= rr_ptr_d;
                        rsp_id_q <= win_s;
                        if (win_err_s) begin
                            // Rejected ops bypass the ALU entirely.
                            state_q      <= RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            rsp_result_q <= 17'h00000;
                            rsp_flags_q  <= 4'b0000;
                        end else begin
                            state_q      <= EXEC;
                            alu_a_q      <= win_a_s;
                            alu_b_q      <= win_b_s;
                            alu_opcode_q <= win_op_s;
                            alu_op_q     <= 1'b1;
                            cnt_q        <= is_muldiv(win_op_s) ? CW'(MULDIV_CYCLES - 1) : '0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        alu_op_q     <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= 1'b0;
                        rsp_result_q <= alu_result;
                        rsp_flags_q  <= alu_flags_s;
                        status_q     <= alu_flags_s;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    alu_op_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_flags    = rsp_flags_q;
    assign rsp_err      = rsp_err_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_op       = alu_op_q;
    assign status_flags = status_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: emulates the shared ALU and checks
// grants, timing and responses against a timestamp-based reference model.
module tb_alu_issue_ctrl;

    localparam int NR  = 2;
    localparam int MDC = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [6*NR-1:0]   req_opcode;
    logic [16*NR-1:0]  req_a;
    logic [16*NR-1:0]  req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [16:0]       rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;
    logic [15:0]       alu_a;
    logic [15:0]       alu_b;
    logic [5:0]        alu_opcode;
    logic              alu_op;
    logic [16:0]       alu_result;
    logic              alu_zf, alu_cf, alu_nf, alu_of;
    logic [3:0]        status_flags;
    logic              busy;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.NUM_REQ(NR), .MULDIV_CYCLES(MDC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zf(alu_zf), .alu_cf(alu_cf),
        .alu_nf(alu_nf), .alu_of(alu_of),
        .status_flags(status_flags), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Requester side
    bit [NR-1:0]  rq_v;
    logic [5:0]   rq_op [NR];
    logic [15:0]  rq_a  [NR];
    logic [15:0]  rq_b  [NR];

    // Reference model: one outstanding op described by its grant time
    bit           pend;
    bit           post_rst;
    int           g_cyc;
    int           lat;
    int           e_id;
    bit           e_err;
    logic [5:0]   e_op;
    logic [15:0]  e_a, e_b;
    logic [16:0]  e_res;
    logic [3:0]   e_flg;
    logic [3:0]   m_status;
    int           m_ptr;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Behavioural ALU: returns {result[16:0], ZF, CF, NF, OF}
    function automatic logic [20:0] alu_ref(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        logic [16:0] r;
        logic c, o;
        p = 32'h0; c = 1'b0; o = 1'b0;
        case (op)
            6'h09: begin r = {1'b0, a} + {1'b0, b}; c = r[16]; o = (a[15] == b[15]) && (r[15] != a[15]); end
            6'h0A: begin r = {1'b0, a} - {1'b0, b}; c = (a >= b); o = (a[15] != b[15]) && (r[15] != a[15]); end
            6'h10: begin p = a * b; r = p[16:0]; c = |p[31:16]; end
            6'h11: r = (b == 16'h0) ? 17'h0 : {1'b0, a / b};
            6'h12: r = (b == 16'h0) ? 17'h0 : {1'b0, a % b};
            6'h13: r = {1'b0, a & b};
            6'h14: r = {1'b0, a | b};
            default: r = {1'b0, a ^ ~b};
        endcase
        return {r, (r[15:0] == 16'h0), c, r[15], o};
    endfunction

    function automatic void gen_req(input int i);
        int sel;
        sel     = $urandom_range(0, 9);
        rq_a[i] = 16'($urandom);
        rq_b[i] = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
        if (sel < 6)       rq_op[i] = 6'($urandom_range(9, 26));
        else if (sel == 6) rq_op[i] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 8)) : 6'($urandom_range(27, 63));
        else if (sel == 7) begin rq_op[i] = ($urandom_range(0, 1) == 1) ? 6'h11 : 6'h12; rq_b[i] = 16'h0; end
        else               rq_op[i] = 6'($urandom_range(16, 18));
        rq_v[i] = 1'b1;
    endfunction

    task automatic set_req(input int i, input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        rq_op[i] = op; rq_a[i] = a; rq_b[i] = b; rq_v[i] = 1'b1;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grant, advance model.
    task automatic step(input bit do_rst, input bit rrdy);
        bit exec_now, fin_now, rsp_now;
        logic [NR-1:0] exp_gnt;
        logic [20:0] ar;
        int w;
        exec_now = pend && (cyc > g_cyc) && (cyc <= g_cyc + lat);
        fin_now  = exec_now && (cyc == g_cyc + lat);
        rsp_now  = pend && (cyc >= g_cyc + lat + 1);
        if (pend && !e_err && (cyc == g_cyc + lat + 1)) m_status = e_flg;

        chk_val("alu_op", alu_op, exec_now);
        chk_val("busy", busy, pend);
        chk_val("rsp_valid", rsp_valid, rsp_now);
        chk_val("status_flags", status_flags, m_status);
        if (exec_now) begin
            chk_val("alu_a", alu_a, e_a);
            chk_val("alu_b", alu_b, e_b);
            chk_val("alu_opcode", alu_opcode, e_op);
        end
        if (rsp_now) begin
            chk_val("rsp_id", rsp_id, e_id);
            chk_val("rsp_err", rsp_err, e_err);
            chk_val("rsp_result", rsp_result, e_err ? 17'h0 : e_res);
            chk_val("rsp_flags", rsp_flags, e_err ? 4'h0 : e_flg);
        end
        if (post_rst) begin
            chk_val("rst_rsp_id", rsp_id, 0);
            chk_val("rst_rsp_result", rsp_result, 0);
            chk_val("rst_rsp_flags", rsp_flags, 0);
            chk_val("rst_rsp_err", rsp_err, 0);
            chk_val("rst_alu_a", alu_a, 0);
            chk_val("rst_alu_b", alu_b, 0);
            chk_val("rst_alu_opcode", alu_opcode, 0);
        end

        rst       = do_rst;
        rsp_ready = rrdy;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = rq_v[i];
            req_opcode[6*i +: 6]  = rq_op[i];
            req_a[16*i +: 16]     = rq_a[i];
            req_b[16*i +: 16]     = rq_b[i];
        end
        if (fin_now) begin
            ar = alu_ref(e_op, e_a, e_b);
            alu_result = ar[20:4];
            {alu_zf, alu_cf, alu_nf, alu_of} = ar[3:0];
        end else begin
            alu_result = 17'($urandom);
            {alu_zf, alu_cf, alu_nf, alu_of} = 4'($urandom);
        end
        #1;
        exp_gnt = '0;
        w = -1;
        if (!pend && !do_rst) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_ptr + k) % NR;
                if (w < 0 && rq_v[j]) w = j;
            end
        end
        if (w >= 0) exp_gnt[w] = 1'b1;
        chk_val("req_ready", req_ready, exp_gnt);

        if (do_rst) begin
            pend = 1'b0; post_rst = 1'b1; m_ptr = 0; m_status = 4'h0; rq_v = '0;
        end else begin
            post_rst = 1'b0;
            if (rsp_now && rrdy) pend = 1'b0;
            if (w >= 0) begin
                pend  = 1'b1;
                g_cyc = cyc;
                e_id  = w;
                e_op  = rq_op[w];
                e_a   = rq_a[w];
                e_b   = rq_b[w];
                e_err = !(e_op >= 6'h09 && e_op <= 6'h1A) || ((e_op == 6'h11 || e_op == 6'h12) && e_b == 16'h0);
                lat   = e_err ? 0 : ((e_op >= 6'h10 && e_op <= 6'h12) ? MDC : 1);
                ar    = alu_ref(e_op, e_a, e_b);
                e_res = ar[20:4];
                e_flg = ar[3:0];
                rq_v[w] = 1'b0;
                m_ptr = (w + 1) % NR;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while ((pend || rq_v != '0) && k < max_cyc) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk_val("drain_timeout", (pend || rq_v != '0), 1'b0);
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0;
        alu_result = 17'h0; {alu_zf, alu_cf, alu_nf, alu_of} = 4'h0;
        rq_v = '0; pend = 1'b0; post_rst = 1'b1; m_ptr = 0; m_status = 4'h0;
        g_cyc = 0; lat = 0; e_id = 0; e_err = 1'b0; e_op = 6'h0; e_a = 16'h0; e_b = 16'h0;
        e_res = 17'h0; e_flg = 4'h0;
        for (int i = 0; i < NR; i++) begin rq_op[i] = 6'h0; rq_a[i] = 16'h0; rq_b[i] = 16'h0; end
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        set_req(0, 6'h09, 16'h0011, 16'h0002);
        drain(20);
        set_req(1, 6'h0A, 16'h0005, 16'h0005);
        drain(20);
        chk_val("sub_status", status_flags, 4'b1100);

        // Both requesters continuously busy: alternate grants
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NR; i++)
                if (!rq_v[i]) set_req(i, 6'h09, 16'($urandom), 16'($urandom));
            step(1'b0, 1'b1);
        end
        drain(40);

        set_req(0, 6'h10, 16'h0100, 16'h0100);
        drain(20);
        chk_val("mul_result", rsp_result, 17'h10000);

        set_req(1, 6'h11, 16'h1234, 16'h0000);
        drain(20);
        set_req(0, 6'h00, 16'h0001, 16'h0001);
        drain(20);

        // Response back-pressure with a competing request waiting
        set_req(0, 6'h09, 16'h0003, 16'h0004);
        set_req(1, 6'h0B, 16'h00F0, 16'h0001);
        step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        drain(40);

        // Reset in the middle of a multicycle op
        set_req(0, 6'h10, 16'h0042, 16'h0007);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++)
                if (!rq_v[i] && $urandom_range(0, 2) == 0) gen_req(i);
            if ($urandom_range(0, 499) == 0) step(1'b1, 1'b0);
            else step(1'b0, ($urandom_range(0, 3) != 0));
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing and sharing controller for the shared 16-bit combinational ALU. Arbitrates round-robin between NUM_REQ requesters (execute stage, address-generation unit) over valid/ready. Registers the granted operands and holds them stable on the ALU for a per-opcode number of cycles, with multicycle timing for MUL/DIV/MOD. Captures result and flags, returns a tagged response, and maintains the architectural status-flag register.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
MULDIV_CYCLES, 3, EXEC cycles for MUL/DIV/MOD (>=1); all other ops take 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot grant/accept pulse
req_opcode  in  6*NUM_REQ  flattened opcodes; requester i at [6i+5:6i]
req_a  in  16*NUM_REQ  flattened operand A
req_b  in  16*NUM_REQ  flattened operand B
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer accept
rsp_id  out  2  index of the originating requester
rsp_result  out  17  captured ALU result (bit 16 = carry/overflow bit)
rsp_flags  out  4  {ZF,CF,NF,OF} captured with the result
rsp_err  out  1  illegal opcode or divide/modulo by zero
alu_a  out  16  ALU operand A (registered)
alu_b  out  16  ALU operand B (registered)
alu_opcode  out  6  ALU opcode (registered)
alu_op  out  1  ALU enable (aluOp); high only in EXEC
alu_result  in  17  ALU result
alu_zf, alu_cf, alu_nf, alu_of  in  1 each  ALU flags
status_flags  out  4  {ZF,CF,NF,OF} from the last successful op
busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, rr pointer 0, req_ready 0, rsp_valid 0, rsp_id/rsp_result/rsp_flags/rsp_err 0, alu_a/alu_b/alu_opcode 0, alu_op 0, status_flags 0, EXEC counter 0. Reset overrides everything. An operation in flight is abandoned and produces no response.
- Legal opcodes: 6'h09..6'h1A (ADD, SUB, LSR, LSL, RSR, RSL, MOV, MUL, DIV, MOD, AND, OR, XOR, NOT, CMP, TST, INC, DEC). MUL=6'h10, DIV=6'h11, MOD=6'h12.
- State IDLE:
  - req_ready is combinational: one-hot to the winning valid requester, searched round-robin from rr pointer upward.
  - Handshake completes in the same cycle; operands, opcode and id are registered.
  - rr pointer <= winner+1 (mod NUM_REQ).
  - No valid requester: stay in IDLE, req_ready=0.
- Grant routing:
  - Illegal opcode, or DIV/MOD with b==0: go to RESP with rsp_err=1, rsp_result=0, rsp_flags=0. ALU is never enabled and status_flags is unchanged.
  - Otherwise go to EXEC. Counter loads MULDIV_CYCLES-1 for MUL/DIV/MOD, else 0.
- State EXEC:
  - alu_op=1 and alu_* held constant.
  - Counter decrements each cycle. At counter==0, capture alu_result and the flags into rsp_*, status_flags <= captured flags, rsp_err=0, then go to RESP.
  - The ALU output is valid only on the final EXEC cycle; earlier cycles are multicycle-path don't-cares.
- State RESP:
  - rsp_valid=1 with all rsp_* stable until rsp_ready=1, then go to IDLE.
  - No new grant while in RESP (req_ready=0).
- Latency:
  - Grant at cycle T, rsp_valid first high at T+L+1, where L = EXEC cycles (1, or MULDIV_CYCLES).
  - Error responses appear at T+1.
  - Minimum issue interval is L+2 cycles.
- alu_op=0 outside EXEC; ALU outputs are ignored then.
- Arithmetic: the controller performs none on data. Widths pass through unchanged; rsp_result is 17 bits exactly as produced by the ALU.
- Simultaneous requests: exactly one grant per IDLE cycle. A non-granted requester keeps req_valid and its operands stable until granted.

Decomposition:
- Shared package alu_ctrl_pkg: opcode localparams (OP_ADD..OP_DEC), OP_MIN/OP_MAX legal bounds, flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0), state encoding (IDLE, EXEC, RESP), is_muldiv / is_legal functions.
- One sub-module: rr_arbiter (NUM_REQ param; inputs req, ptr; output one-hot grant), instantiated once.

Test Plan:
- Requester 0 ADD, a=16'h0011, b=16'h0002 -> single grant, alu_op high for 1 cycle, rsp_valid at T+2, rsp_result=17'h00013, rsp_flags=4'b0000, rsp_id=0, rsp_err=0.
- Requester 1 SUB, a=b=16'h0005 -> rsp_result=17'h00000, rsp_flags=4'b1100 (ZF=1, CF=1), status_flags=4'b1100.
- Both requesters valid continuously with ADD after reset -> grant order 0,1,0,1; each rsp_id matches its grant; no cycle has two req_ready bits set.
- MUL, a=16'h0100, b=16'h0100, MULDIV_CYCLES=3 -> alu_op high exactly 3 cycles, rsp_valid at T+4, rsp_result=17'h10000, CF=1.
- DIV, b=0, then opcode 6'h00 -> both give rsp_err=1 at T+1, alu_op never asserted, status_flags unchanged.
- rsp_ready held low 4 cycles with another request pending -> rsp_* stable, req_ready stays 0. Separately, rst pulsed during EXEC -> all outputs return to 0 next cycle and no response is issued.
